// File: rtl/trend_pkg.sv
// Shared definitions for the weighted-majority trend detector and its
// stream source, so the shadow model and the detector use the same
// weights and thresholds.
package trend_pkg;

  // Window length and the weight applied to each window position.
  // Position 0 holds the newest bit and carries the heaviest weight.
  localparam int WIN_LEN = 4;
  localparam logic [3:0] TREND_WEIGHT [WIN_LEN] = '{4'd8, 4'd4, 4'd2, 4'd1};

  // Hysteresis thresholds on the weighted sum.
  localparam logic [3:0] TREND_HI = 4'd8;
  localparam logic [3:0] TREND_LO = 4'd4;

  // Serializer states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Weighted sum of a window. The maximum is 8+4+2+1 = 15, so 4 bits never overflow.
  function automatic logic [3:0] window_sum(input logic [WIN_LEN-1:0] w);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < WIN_LEN; i++) begin
      if (w[i]) begin
        s = s + TREND_WEIGHT[i];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/wm_trend_model.sv
// Shadow model of the weighted-majority trend detector: a 4-bit window
// of recent stream bits with a hysteresis decision on the weighted sum.
module wm_trend_model
  import trend_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic bit_in,
  output logic trend
);

  logic [WIN_LEN-1:0] r_win;
  logic               r_trend;
  logic [WIN_LEN-1:0] w_win_next;
  logic [3:0]         w_sum_next;

  // The decision is taken on the window that already includes the incoming bit.
  assign w_win_next = {r_win[WIN_LEN-2:0], bit_in};
  assign w_sum_next = window_sum(w_win_next);
  assign trend      = r_trend;

  // Shift the window once per presented bit and update the trend with hysteresis.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win   <= {WIN_LEN{1'b0}};
      r_trend <= 1'b0;
    end else if (shift_en) begin
      r_win <= w_win_next;
      if (w_sum_next >= TREND_HI) begin
        r_trend <= 1'b1;
      end else if (w_sum_next < TREND_LO) begin
        r_trend <= 1'b0;
      end else begin
        r_trend <= r_trend;
      end
    end else begin
      r_win   <= r_win;
      r_trend <= r_trend;
    end
  end

endmodule

// File: rtl/trend_stream_tx.sv
// Serial stream source for the trend detector. Words are accepted over a
// valid/ready handshake and sent MSB-first. Each bit is held for div+1
// cycles, and each word is sent rep+1 times. A new command can be accepted
// in the last cycle of the current one, which gives a gapless stream.
module trend_stream_tx
  import trend_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int REP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DIV_W-1:0]  in_div,
  input  logic [REP_W-1:0]  in_repeat,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done,
  output logic              exp_trend
);

  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [REP_W-1:0]  r_rep;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;

  logic w_send;
  logic w_bit_end;
  logic w_word_end;
  logic w_last;
  logic w_accept;

  // All outputs are decoded from registers only. Because of this, an
  // asynchronous reset clears them at once.
  assign w_send     = (r_state == SEND);
  assign w_bit_end  = w_send && (r_div_cnt == r_div);
  assign w_word_end = w_bit_end && (r_bit_cnt == LAST_BIT);
  assign w_last     = w_word_end && (r_rep_cnt == r_rep);
  assign w_accept   = in_valid && in_ready;

  assign in_ready   = !w_send || w_last;
  assign bit_out    = w_send && r_shift[DATA_W-1];
  assign bit_strobe = w_send && (r_div_cnt == {DIV_W{1'b0}});
  assign busy       = w_send;
  assign done       = w_last;

  // Serializer FSM: accept a command, then step the divider, bit and repeat counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_word    <= {DATA_W{1'b0}};
      r_shift   <= {DATA_W{1'b0}};
      r_div     <= {DIV_W{1'b0}};
      r_div_cnt <= {DIV_W{1'b0}};
      r_rep     <= {REP_W{1'b0}};
      r_rep_cnt <= {REP_W{1'b0}};
      r_bit_cnt <= {BIT_W{1'b0}};
    end else if (w_accept) begin
      // An accept is only possible in IDLE or in the final cycle of a command.
      r_state   <= SEND;
      r_word    <= in_data;
      r_shift   <= in_data;
      r_div     <= in_div;
      r_rep     <= in_repeat;
      r_div_cnt <= {DIV_W{1'b0}};
      r_rep_cnt <= {REP_W{1'b0}};
      r_bit_cnt <= {BIT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        SEND: begin
          if (w_last) begin
            r_state   <= IDLE;
            r_shift   <= {DATA_W{1'b0}};
            r_div_cnt <= {DIV_W{1'b0}};
            r_rep_cnt <= {REP_W{1'b0}};
            r_bit_cnt <= {BIT_W{1'b0}};
          end else if (w_word_end) begin
            r_shift   <= r_word;
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
            r_bit_cnt <= {BIT_W{1'b0}};
            r_div_cnt <= {DIV_W{1'b0}};
          end else if (w_bit_end) begin
            r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_div_cnt <= {DIV_W{1'b0}};
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Shadow detector, fed with every newly presented bit.
  wm_trend_model u_wm_trend_model (
    .clk      (clk),
    .reset    (reset),
    .shift_en (bit_strobe),
    .bit_in   (bit_out),
    .trend    (exp_trend)
  );

endmodule

// File: tb/tb_trend_stream_tx.sv
// Scoreboard bench for trend_stream_tx. The driver expands each accepted
// command into expected bits using a reference model kept in the bench.
// A monitor consumes those bits whenever the DUT presents one.
module tb_trend_stream_tx;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;
  localparam int REP_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DIV_W-1:0]  in_div = '0;
  logic [REP_W-1:0]  in_repeat = '0;
  logic              bit_out;
  logic              bit_strobe;
  logic              busy;
  logic              done;
  logic              exp_trend;

  trend_stream_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W), .REP_W(REP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_div     (in_div),
    .in_repeat  (in_repeat),
    .bit_out    (bit_out),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .done       (done),
    .exp_trend  (exp_trend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic trend;
    logic last;
    int   hold;
  } item_t;

  item_t exp_q[$];
  bit    hist[$];
  logic  model_trend = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: expand a command into its bit sequence. The trend is
  // derived from the last four transmitted bits with weights 8,4,2,1.
  task automatic model_push(input logic [DATA_W-1:0] d, input int dv, input int rp);
    item_t it;
    int    sum;
    for (int r = 0; r <= rp; r++) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        hist.push_front(d[i]);
        if (hist.size() > 4) void'(hist.pop_back());
        sum = 0;
        for (int k = 0; k < hist.size(); k++) sum += (hist[k] ? (8 >> k) : 0);
        if (sum >= 8) model_trend = 1'b1;
        else if (sum < 4) model_trend = 1'b0;
        it.b     = d[i];
        it.trend = model_trend;
        it.last  = (r == rp) && (i == 0);
        it.hold  = dv;
        exp_q.push_back(it);
      end
    end
  endtask

  // Present a command and hold it until it is accepted. After the accept,
  // scramble the fields to confirm that they were latched.
  task automatic send(input logic [DATA_W-1:0] d, input int dv, input int rp, input bit b2b);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_div    = DIV_W'(dv);
    in_repeat = REP_W'(rp);
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 2000) begin
        fail_now("accept_timeout");
        in_valid = 1'b0;
        return;
      end
    end
    if (b2b) begin
      check("b2b_accept_on_done", done, 1'b1);
      check("b2b_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1;
    model_push(d, dv, rp);
    in_valid  = 1'b0;
    in_data   = DATA_W'($urandom);
    in_div    = DIV_W'($urandom);
    in_repeat = REP_W'($urandom);
  endtask

  int   hold_rem = 0;
  logic cur_b = 1'b0;
  logic cur_last = 1'b0;
  bit   trend_pend = 1'b0;
  logic trend_exp = 1'b0;
  item_t mon_it;

  // Monitor: pop one expected bit per strobe and check it over its whole hold period.
  always @(negedge clk) begin
    if (reset) begin
      hold_rem   = 0;
      trend_pend = 1'b0;
    end else begin
      if (trend_pend) begin
        check("exp_trend", exp_trend, trend_exp);
        trend_pend = 1'b0;
      end
      if (hold_rem > 0) begin
        check("strobe_hold", bit_strobe, 1'b0);
        check("bit_hold", bit_out, cur_b);
        check("busy_hold", busy, 1'b1);
        check("done_hold", done, cur_last && (hold_rem == 1));
        check("ready_hold", in_ready, cur_last && (hold_rem == 1));
        hold_rem--;
      end else if (bit_strobe) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_strobe");
        end else begin
          mon_it = exp_q.pop_front();
          check("bit_out", bit_out, mon_it.b);
          check("busy_send", busy, 1'b1);
          check("done_strobe", done, mon_it.last && (mon_it.hold == 0));
          check("ready_strobe", in_ready, mon_it.last && (mon_it.hold == 0));
          hold_rem   = mon_it.hold;
          cur_b      = mon_it.b;
          cur_last   = mon_it.last;
          trend_exp  = mon_it.trend;
          trend_pend = 1'b1;
        end
      end else begin
        check("busy_idle", busy, 1'b0);
        check("bit_idle", bit_out, 1'b0);
        check("done_idle", done, 1'b0);
        check("ready_idle", in_ready, 1'b1);
        if (exp_q.size() != 0) fail_now("missing_strobe");
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 || hold_rem != 0 || busy !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        fail_now("idle_timeout");
        return;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_bit_out"}, bit_out, 1'b0);
    check({tag, "_bit_strobe"}, bit_strobe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_exp_trend"}, exp_trend, 1'b0);
  endtask

  // Assert reset away from either clock edge and check that outputs clear at once.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    hist.delete();
    model_trend = 1'b0;
    #1;
    check_reset_values(tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check_reset_values("reset_init");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    send(8'hA5, 0, 0, 1'b0);
    wait_idle();
    send(8'h81, 2, 0, 1'b0);
    wait_idle();
    send(8'hFF, 0, 0, 1'b0);
    send(8'h00, 0, 0, 1'b1);
    wait_idle();
    send(8'hF0, 0, 1, 1'b0);
    wait_idle();
    send(8'h3C, 1, 1, 1'b0);
    send(8'h5A, 0, 2, 1'b1);
    wait_idle();

    pulse_reset("reset_idle");
    send(8'hFF, 2, 1, 1'b0);
    repeat (7) @(posedge clk);
    pulse_reset("reset_mid");
    send(8'h0F, 0, 0, 1'b0);
    wait_idle();

    for (int n = 0; n < 30; n++) begin
      bit b2b;
      b2b = ($urandom_range(0, 1) == 1) && (n > 0);
      if (!b2b) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      send(DATA_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), b2b);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
